// File: rtl/mips_mem_sequencer.sv
// Multi-cycle sequencer between mips_decode and data memory.
// Holds PC/IR with stall while a load, store or ADDM waits for memory.
// It orders ADDM as a memory read followed by an ALU add. It commits the
// register write only for completed instructions that raised no exception.
module mips_mem_sequencer #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inst_valid,
  input  logic             writeenable_in,
  input  logic             except,
  input  logic             mem_read,
  input  logic             word_we,
  input  logic             byte_we,
  input  logic             byte_load,
  input  logic             addm,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_byte,
  output logic             mdr_we,
  output logic             alu_mem_sel,
  output logic             stall,
  output logic             rf_we,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM     = 2'd1,
    ADDM_EX = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              memop;

  assign memop = inst_valid & ~except & (mem_read | word_we | byte_we | addm);
  assign state = state_q;
  assign stall_count = stall_cnt_q;

  // Next-state and output decode; decoder inputs are stable while stalled.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    err_d       = err_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_byte    = 1'b0;
    mdr_we      = 1'b0;
    alu_mem_sel = 1'b0;
    stall       = 1'b0;
    rf_we       = 1'b0;
    bus_error   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall   = 1'b1;
          state_d = MEM;
          wait_d  = '0;
          err_d   = 1'b0;
        end else begin
          rf_we = inst_valid & writeenable_in & ~except;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        stall    = 1'b1;
        mem_we   = word_we | byte_we;
        mem_byte = byte_we | byte_load;
        if (mem_ack) begin
          // An ack arriving on the last allowed cycle still completes the access.
          mdr_we  = mem_read | addm;
          state_d = addm ? ADDM_EX : DONE;
        end else if (wait_q == WAIT_LAST) begin
          bus_error = 1'b1;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ADDM_EX: begin
        stall       = 1'b1;
        alu_mem_sel = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        alu_mem_sel = addm | mem_read;
        rf_we       = writeenable_in & ~err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, access wait counter and timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Self-checking bench for mips_mem_sequencer: each instruction is expanded
// into its expected per-cycle output rows, checked on the falling edge.
module tb_mips_mem_sequencer;

  localparam int MW = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    int st;
    bit req, we, byt, mdr, ams, stl, rfw, berr;
    int cnt;
  } row_t;

  logic clock = 1'b0;
  logic reset, inst_valid, writeenable_in, except;
  logic mem_read, word_we, byte_we, byte_load, addm, mem_ack;
  logic mem_req, mem_we, mem_byte, mdr_we, alu_mem_sel, stall, rf_we, bus_error;
  logic [CW-1:0] stall_count;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  row_t exp_row;
  bit exp_valid = 1'b0;

  always #5 clock = ~clock;

  mips_mem_sequencer #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .inst_valid(inst_valid),
    .writeenable_in(writeenable_in), .except(except), .mem_read(mem_read),
    .word_we(word_we), .byte_we(byte_we), .byte_load(byte_load), .addm(addm),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mdr_we(mdr_we), .alu_mem_sel(alu_mem_sel), .stall(stall), .rf_we(rf_we),
    .bus_error(bus_error), .stall_count(stall_count), .state(state)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Single compare point: every meaningful cycle against the model row.
  always @(negedge clock) begin
    if (exp_valid) begin
      chk("state", int'(state), exp_row.st);
      chk("mem_req", int'(mem_req), int'(exp_row.req));
      chk("mem_we", int'(mem_we), int'(exp_row.we));
      chk("mem_byte", int'(mem_byte), int'(exp_row.byt));
      chk("mdr_we", int'(mdr_we), int'(exp_row.mdr));
      chk("alu_mem_sel", int'(alu_mem_sel), int'(exp_row.ams));
      chk("stall", int'(stall), int'(exp_row.stl));
      chk("rf_we", int'(rf_we), int'(exp_row.rfw));
      chk("bus_error", int'(bus_error), int'(exp_row.berr));
      chk("stall_count", int'(stall_count), exp_row.cnt);
    end
  end

  function automatic row_t blank(input int st);
    row_t r;
    r.st = st; r.req = 0; r.we = 0; r.byt = 0; r.mdr = 0;
    r.ams = 0; r.stl = 0; r.rfw = 0; r.berr = 0; r.cnt = 0;
    return r;
  endfunction

  // One clock cycle: present inputs/expectation, advance the model counter.
  task automatic step(input row_t r, input logic ack);
    r.cnt = model_cnt;
    mem_ack = ack;
    exp_row = r;
    exp_valid = 1'b1;
    @(posedge clock);
    #1;
    if (reset) model_cnt = 0;
    else if (r.stl && model_cnt < CMAX) model_cnt++;
  endtask

  // Expands one decoded instruction into its cycle sequence.
  // k = MEM cycle on which ack arrives (0 = never); noise = ack level outside MEM.
  task automatic run_instr(input bit iv, input bit we, input bit ex,
                           input bit mr, input bit ww, input bit bw,
                           input bit bl, input bit am, input int k,
                           input bit noise);
    row_t r;
    bit acked, ack;
    inst_valid = iv; writeenable_in = we; except = ex;
    mem_read = mr; word_we = ww; byte_we = bw; byte_load = bl; addm = am;
    if (!(iv && !ex && (mr || ww || bw || am))) begin
      r = blank(0);
      r.rfw = iv & we & ~ex;
      step(r, noise);
      return;
    end
    r = blank(0);
    r.stl = 1;
    step(r, noise);
    acked = 0;
    for (int i = 1; i <= MW; i++) begin
      ack = (k == i);
      r = blank(1);
      r.req = 1; r.stl = 1; r.we = ww | bw; r.byt = bw | bl;
      r.mdr = ack & (mr | am);
      r.berr = !ack && (i == MW);
      step(r, ack);
      if (ack) begin
        acked = 1;
        break;
      end
    end
    if (acked && am) begin
      r = blank(2);
      r.stl = 1; r.ams = 1;
      step(r, noise);
    end
    r = blank(3);
    r.ams = am | mr;
    r.rfw = we & acked;
    step(r, noise);
  endtask

  initial begin
    row_t r;
    reset = 1'b1; inst_valid = 0; writeenable_in = 0; except = 0;
    mem_read = 0; word_we = 0; byte_we = 0; byte_load = 0; addm = 0; mem_ack = 0;
    @(posedge clock); #1;
    model_cnt = 0;
    step(blank(0), 1'b0);            // reset state
    reset = 1'b0;

    //        iv we ex mr ww bw bl am  k noise
    run_instr(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);   // ADD
    run_instr(1, 1, 0, 1, 0, 0, 0, 0, 3, 0);   // LW, ack on 3rd MEM cycle
    chk("cnt_after_lw", int'(stall_count), 4);
    run_instr(1, 1, 0, 0, 0, 0, 0, 1, 1, 1);   // ADDM, ack on 1st
    chk("cnt_after_addm", int'(stall_count), 7);
    run_instr(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);   // SB, never acked -> timeout
    chk("cnt_after_sb", int'(stall_count), 12);
    run_instr(1, 1, 1, 1, 0, 0, 1, 0, 1, 1);   // LBU with exception
    run_instr(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);   // ADD with stray ack
    run_instr(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);   // bubble
    run_instr(1, 0, 0, 0, 1, 0, 0, 0, 2, 0);   // SW, ack on 2nd
    chk("cnt_after_sw", int'(stall_count), 15);
    run_instr(1, 1, 0, 1, 0, 0, 0, 0, MW, 0);  // LW, ack on last allowed cycle
    chk("cnt_saturated", int'(stall_count), 15);
    run_instr(1, 1, 0, 0, 0, 0, 0, 1, 2, 0);   // ADDM, ack on 2nd

    // Reset in the middle of an LW access, then a late ack.
    inst_valid = 1; writeenable_in = 1; except = 0;
    mem_read = 1; word_we = 0; byte_we = 0; byte_load = 0; addm = 0;
    r = blank(0); r.stl = 1;
    step(r, 1'b0);
    r = blank(1); r.req = 1; r.stl = 1;
    step(r, 1'b0);
    reset = 1'b1;
    step(r, 1'b0);
    reset = 1'b0;
    inst_valid = 0; mem_read = 0; writeenable_in = 0;
    step(blank(0), 1'b1);
    step(blank(0), 1'b1);
    chk("cnt_after_reset", int'(stall_count), 0);
    chk("state_after_reset", int'(state), 0);

    exp_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
